gpio_in_irq: RTL

- Input-side companion to the GPIO pad mux.
- Receives the raw pad input vector (gpio_in) and synchronizes it.
- Optionally debounces it, exposes it for reading, and generates a per-pin edge/level interrupt with a pending register.
- Sits on the sysio peripheral bus next to the pad mux; irq_o goes to the interrupt controller.

---
 rtl/gpio_in_irq_pkg.sv | 18 +
 rtl/gpio_dbnc.sv | 51 +++++
 rtl/gpio_in_irq.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/gpio_in_irq_pkg.sv
// Register offsets and shared helpers for the GPIO input / interrupt block.
// Offsets match the pad mux and software headers.
package gpio_in_irq_pkg;

    localparam logic [7:0] GPIO_DIN   = 8'h00;
    localparam logic [7:0] GPIO_IEN   = 8'h04;
    localparam logic [7:0] GPIO_ITYPE = 8'h08;
    localparam logic [7:0] GPIO_IPOL  = 8'h0C;
    localparam logic [7:0] GPIO_IPEND = 8'h10;
    localparam logic [7:0] GPIO_DBC   = 8'h14;

    localparam int GPIO_DB_CNT_W = 16;

    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        byte_mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/gpio_dbnc.sv
// Shared debounce prescaler plus per-pin 3-sample agreement filter; output is registered.
// No backpressure: free-running, the prescaler restarts whenever the period is rewritten.
module gpio_dbnc #(
    parameter int NPIN     = 32,
    parameter int DB_CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DB_CNT_W-1:0] i_cfg,
    input  logic                i_restart,
    input  logic [NPIN-1:0]     i_s,
    output logic [NPIN-1:0]     o_f
);

    logic [DB_CNT_W-1:0] r_cnt;
    logic [NPIN-1:0]     r_h0;
    logic [NPIN-1:0]     r_h1;
    logic [NPIN-1:0]     r_f;
    logic                w_tick;
    logic [NPIN-1:0]     w_all1;
    logic [NPIN-1:0]     w_all0;

    assign w_tick = (r_cnt == i_cfg) && !i_restart;

    // The incoming sample is the newest of the three, so a change settles in 3 ticks.
    assign w_all1 = i_s & r_h0 & r_h1;
    assign w_all0 = ~(i_s | r_h0 | r_h1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_h0  <= '0;
            r_h1  <= '0;
            r_f   <= '0;
        end else begin
            if (i_restart || w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + DB_CNT_W'(1);
            end
            if (w_tick) begin
                r_h1 <= r_h0;
                r_h0 <= i_s;
                r_f  <= (r_f | w_all1) & ~w_all0;
            end
        end
    end

    assign o_f = r_f;

endmodule

// File: rtl/gpio_in_irq.sv
// GPIO input sync, optional debounce (GPIO_DEBOUNCE_EN), per-pin edge/level irq; reads 1 cycle, irq 1 cycle after IPEND.
// No backpressure: single-cycle register writes and reads, level interrupt output.
module gpio_in_irq
    import gpio_in_irq_pkg::*;
#(
    parameter int NPIN        = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CNT_W    = GPIO_DB_CNT_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  waddr_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  sel_i,
    input  logic        we_i,
    input  logic [7:0]  raddr_i,
    input  logic        rd_i,
    output logic [31:0] data_o,
    input  logic [31:0] gpio_in,
    output logic        irq_o
);

    localparam int VCW = $clog2(SYNC_STAGES + 2);

    logic [NPIN-1:0]     r_sync [SYNC_STAGES];
    logic [NPIN-1:0]     r_p;
    logic [NPIN-1:0]     r_ien;
    logic [NPIN-1:0]     r_itype;
    logic [NPIN-1:0]     r_ipol;
    logic [NPIN-1:0]     r_ipend;
    logic [VCW-1:0]      r_vcnt;
    logic                r_valid;

    logic [NPIN-1:0]     w_s;
    logic [NPIN-1:0]     w_f;
    logic [31:0]         w_bmask;
    logic [NPIN-1:0]     w_wm;
    logic [NPIN-1:0]     w_wd;
    logic [NPIN-1:0]     w_edge;
    logic [NPIN-1:0]     w_level;
    logic [NPIN-1:0]     w_cond;
    logic [NPIN-1:0]     w_clr;
    logic [DB_CNT_W-1:0] w_dbcfg;
    logic [31:0]         w_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            r_sync[0] <= gpio_in[NPIN-1:0];
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign w_s     = r_sync[SYNC_STAGES-1];
    assign w_bmask = byte_mask(sel_i);
    assign w_wm    = w_bmask[NPIN-1:0];
    assign w_wd    = data_i[NPIN-1:0];

`ifdef GPIO_DEBOUNCE_EN
    logic [DB_CNT_W-1:0] r_dbcfg;
    logic                w_we_dbc;

    assign w_we_dbc = we_i && (waddr_i == GPIO_DBC);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dbcfg <= '0;
        end else if (w_we_dbc) begin
            r_dbcfg <= (r_dbcfg & ~w_bmask[DB_CNT_W-1:0])
                     | (data_i[DB_CNT_W-1:0] & w_bmask[DB_CNT_W-1:0]);
        end
    end

    assign w_dbcfg = r_dbcfg;

    gpio_dbnc #(
        .NPIN     (NPIN),
        .DB_CNT_W (DB_CNT_W)
    ) u_dbnc (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_cfg     (r_dbcfg),
        .i_restart (w_we_dbc),
        .i_s       (w_s),
        .o_f       (w_f)
    );
`else
    assign w_dbcfg = '0;
    assign w_f     = w_s;
`endif

    // Valid rises once the synchronizer has flushed its reset zeros, masking false edges.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vcnt  <= '0;
            r_valid <= 1'b0;
            r_p     <= '0;
        end else begin
            r_p <= w_f;
            if (!r_valid) begin
                r_vcnt  <= r_vcnt + VCW'(1);
                r_valid <= (r_vcnt == VCW'(SYNC_STAGES));
            end
        end
    end

    assign w_edge  = r_valid ? ((r_ipol & w_f & ~r_p) | (~r_ipol & ~w_f & r_p)) : '0;
    assign w_level = (r_ipol & w_f) | (~r_ipol & ~w_f);
    assign w_cond  = (r_itype & w_edge) | (~r_itype & w_level);
    assign w_clr   = (we_i && (waddr_i == GPIO_IPEND)) ? (w_wd & w_wm) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ien   <= '0;
            r_itype <= '0;
            r_ipol  <= '0;
            r_ipend <= '0;
            irq_o   <= 1'b0;
        end else begin
            if (we_i && (waddr_i == GPIO_IEN)) begin
                r_ien <= (r_ien & ~w_wm) | (w_wd & w_wm);
            end
            if (we_i && (waddr_i == GPIO_ITYPE)) begin
                r_itype <= (r_itype & ~w_wm) | (w_wd & w_wm);
            end
            if (we_i && (waddr_i == GPIO_IPOL)) begin
                r_ipol <= (r_ipol & ~w_wm) | (w_wd & w_wm);
            end
            // A new set in the same cycle as a clear keeps the bit pending.
            r_ipend <= (r_ipend & ~w_clr) | (w_cond & r_ien);
            irq_o   <= |(r_ipend & r_ien);
        end
    end

    always_comb begin
        w_rdata = '0;
        case (raddr_i)
            GPIO_DIN:   w_rdata = 32'(w_f);
            GPIO_IEN:   w_rdata = 32'(r_ien);
            GPIO_ITYPE: w_rdata = 32'(r_itype);
            GPIO_IPOL:  w_rdata = 32'(r_ipol);
            GPIO_IPEND: w_rdata = 32'(r_ipend);
            GPIO_DBC:   w_rdata = 32'(w_dbcfg);
            default:    w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_o <= '0;
        end else if (rd_i) begin
            data_o <= w_rdata;
        end
    end

endmodule
